// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the PLL bring-up / reset sequencer.
package rst_seq_pkg;

   typedef enum logic [2:0] {
      PLL_RST,
      WAIT_LOCK,
      STABLE,
      RELEASE,
      RUN,
      FAULT
   } state_t;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int cnt_w(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser for asynchronous level inputs.
module bit_sync #(
   parameter int W = 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] s1_q, s2_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/rst_seq_ctl.sv
// PLL bring-up with lock qualification, timeout/retry, and staged release
// of N_RST active-low downstream resets.
module rst_seq_ctl
   import rst_seq_pkg::*;
#(
   parameter int N_RST               = 4,
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int STEP_CYCLES         = 256,
   parameter int MAX_RETRY           = 3
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic                           pll_locked_in,
   input  logic                           sw_rst_in,
   output logic                           pll_rst_out,
   output logic [N_RST-1:0]               rst_n_out,
   output logic                           ready_out,
   output logic                           fault_out,
   output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt_out
);

   localparam int REL_SPAN = (N_RST - 1) * STEP_CYCLES;
   localparam int MAX_A    = (PLL_RST_CYCLES - 1 > LOCK_STABLE_CYCLES) ?
                             PLL_RST_CYCLES - 1 : LOCK_STABLE_CYCLES;
   localparam int MAX_C    = (MAX_A > REL_SPAN) ? MAX_A : REL_SPAN;
   localparam int CW       = cnt_w(MAX_C);
   localparam int TW       = cnt_w(LOCK_TIMEOUT_CYCLES);
   localparam int RW       = $clog2(MAX_RETRY + 1);

   localparam logic [CW-1:0] PLL_LAST = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] STAB_LIM = CW'(LOCK_STABLE_CYCLES);
   localparam logic [CW-1:0] REL_LAST = CW'(REL_SPAN);
   localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [RW-1:0] RMAX     = RW'(MAX_RETRY);

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;     // PLL pulse / stable / step counter
   logic [TW-1:0]     to_q, to_d;
   logic [RW-1:0]     retry_q, retry_d;
   logic              pll_rst_q, pll_rst_d;
   logic [N_RST-1:0]  rst_n_q, rst_n_d;
   logic              ready_q, ready_d;
   logic              fault_q, fault_d;
   logic              lock_s;
   logic              to_hit;

   bit_sync #(.W(1)) u_lock_sync (
      .clk_i (clk_in),
      .rst_i (rst_in),
      .d_i   (pll_locked_in),
      .q_o   (lock_s)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= PLL_RST;
         cnt_q     <= '0;
         to_q      <= '0;
         retry_q   <= '0;
         pll_rst_q <= 1'b1;
         rst_n_q   <= '0;
         ready_q   <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         to_q      <= to_d;
         retry_q   <= retry_d;
         pll_rst_q <= pll_rst_d;
         rst_n_q   <= rst_n_d;
         ready_q   <= ready_d;
         fault_q   <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      to_d    = to_q;
      retry_d = retry_q;
      to_hit  = (state_q == WAIT_LOCK || state_q == STABLE) && (to_q == TO_LAST);

      case (state_q)
         PLL_RST: begin
            if (cnt_q == PLL_LAST) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
               to_d    = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         WAIT_LOCK: begin
            to_d = to_q + TW'(1);
            if (lock_s) begin
               state_d = STABLE;
               cnt_d   = CW'(1);
            end
         end
         STABLE: begin
            to_d = to_q + TW'(1);
            if (!lock_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == STAB_LIM) begin
               state_d = RELEASE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RELEASE: begin
            if (!lock_s) begin
               state_d = PLL_RST;
               cnt_d   = '0;
            end else if (cnt_q == REL_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RUN: begin
            if (!lock_s) begin
               state_d = PLL_RST;
               cnt_d   = '0;
            end
         end
         FAULT: ;
         default: begin
            state_d = PLL_RST;
            cnt_d   = '0;
         end
      endcase

      // Timeout overrides any lock-driven transition taken above.
      if (to_hit) begin
         retry_d = (retry_q == RMAX) ? retry_q : retry_q + RW'(1);
         state_d = (retry_d == RMAX) ? FAULT : PLL_RST;
         cnt_d   = '0;
      end

      if (state_d == RUN) retry_d = '0;

      if (sw_rst_in) begin
         state_d = PLL_RST;
         cnt_d   = '0;
         to_d    = '0;
         retry_d = '0;
      end

      // Outputs are registered from the next state so each one is glitch-free.
      pll_rst_d = (state_d == PLL_RST) || (state_d == FAULT);
      ready_d   = (state_d == RUN);
      fault_d   = (state_d == FAULT);
      rst_n_d   = '0;
      for (int k = 0; k < N_RST; k++) begin
         rst_n_d[k] = (state_d == RUN) ||
                      ((state_d == RELEASE) && (int'(cnt_d) >= k * STEP_CYCLES));
      end
   end

   assign pll_rst_out   = pll_rst_q;
   assign rst_n_out     = rst_n_q;
   assign ready_out     = ready_q;
   assign fault_out     = fault_q;
   assign retry_cnt_out = retry_q;

endmodule
